// File: rtl/fc_layer_tmux.sv
// Time-multiplexed fully-connected layer: NUM_NEURON neurons share LANES MAC
// lanes. One input vector is buffered, then each group of LANES neurons is
// accumulated, biased, activated and streamed out before the next group runs.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds data stable while valid is high and ready
// is low; ready never depends combinationally on valid.
module fc_layer_tmux #(
  parameter int NUM_NEURON = 10,
  parameter int NUM_INPUT  = 10,
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 16,
  parameter int INT_WIDTH  = 1,
  parameter int LAYER_NUM  = 5,
  parameter     ACT_TYPE   = "relu",
  localparam int IDX_W     = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  weightValid,
  input  logic                  biasValid,
  input  logic [31:0]           weightValue,
  input  logic [31:0]           biasValue,
  input  logic [31:0]           config_layer_num,
  input  logic [31:0]           config_neuron_num,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [IDX_W-1:0]      o_index,
  output logic                  o_last,
  output logic                  busy
);

  localparam int DW     = DATA_WIDTH;
  localparam int FRAC   = DATA_WIDTH - INT_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(NUM_INPUT) + 1;
  localparam int NGROUP = (NUM_NEURON + LANES - 1) / LANES;
  localparam int XW     = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int GW     = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // State is kept as a named enum so checkers can bind to it hierarchically.
  typedef enum logic [1:0] {S_FILL, S_MAC, S_ACT, S_OUT} state_t;
  state_t state, state_nxt;

  logic signed [DW-1:0]    w_mem [NUM_NEURON][NUM_INPUT];
  logic signed [DW-1:0]    b_mem [NUM_NEURON];
  logic signed [DW-1:0]    x_buf [NUM_INPUT];
  logic signed [ACC_W-1:0] acc   [LANES];
  logic signed [DW-1:0]    res   [LANES];

  logic [XW-1:0] xcnt, icnt, wcnt, w_col;
  logic [GW-1:0] grp;
  logic [LW-1:0] lcnt;
  logic [31:0]   wlast;

  logic       cfg_hit, w_acc, b_acc, x_last, i_last, out_end, out_final;
  logic [IDX_W-1:0] cfg_n;
  int         out_n;

  int                      lane_n  [LANES];
  logic                    lane_ok [LANES];
  logic [IDX_W-1:0]        lane_ix [LANES];
  logic signed [2*DW-1:0]  prod    [LANES];
  logic signed [ACC_W-1:0] sum_s   [LANES];
  logic signed [ACC_W-1:0] shf     [LANES];
  logic signed [DW-1:0]    act_val [LANES];

  logic unused_bits;
  assign unused_bits = ^{weightValue[31:DW], biasValue[31:DW]};

  // Config writes are only taken while idle and addressed to this layer.
  assign cfg_hit = (config_layer_num == 32'(LAYER_NUM)) &&
                   (config_neuron_num < 32'(NUM_NEURON)) && !busy;
  assign w_acc   = weightValid && cfg_hit;
  assign b_acc   = biasValid && cfg_hit;
  assign cfg_n   = config_neuron_num[IDX_W-1:0];
  assign w_col   = (config_neuron_num != wlast) ? '0 : wcnt;

  assign x_last    = (xcnt == XW'(NUM_INPUT - 1));
  assign i_last    = (icnt == XW'(NUM_INPUT - 1));
  assign out_n     = int'(grp) * LANES + int'(lcnt);
  assign out_final = (out_n == NUM_NEURON - 1);
  assign out_end   = out_final || (lcnt == LW'(LANES - 1));

  // Weight/bias storage survives reset so a reset only discards work in flight.
  always_ff @(posedge clk) begin
    if (w_acc) w_mem[cfg_n][w_col] <= weightValue[DW-1:0];
    if (b_acc) b_mem[cfg_n] <= biasValue[DW-1:0];
  end

  // Weight write pointer: restarts at 0 whenever the target neuron changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      wlast <= '0;
    end else if (w_acc) begin
      wlast <= config_neuron_num;
      wcnt  <= (w_col == XW'(NUM_INPUT - 1)) ? '0 : w_col + XW'(1);
    end
  end

  // Per-lane MAC product and bias/shift/saturate/activation for the ACT step.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_n[l]  = int'(grp) * LANES + l;
      lane_ok[l] = (lane_n[l] < NUM_NEURON);
      lane_ix[l] = lane_ok[l] ? IDX_W'(lane_n[l]) : '0;
      prod[l]    = x_buf[icnt] * w_mem[lane_ix[l]][icnt];
      sum_s[l]   = acc[l] + (ACC_W'(b_mem[lane_ix[l]]) <<< FRAC);
      shf[l]     = sum_s[l] >>> FRAC;
      if (shf[l] > SAT_MAX)      act_val[l] = {1'b0, {(DW-1){1'b1}}};
      else if (shf[l] < SAT_MIN) act_val[l] = {1'b1, {(DW-1){1'b0}}};
      else                       act_val[l] = shf[l][DW-1:0];
      if (ACT_TYPE == "relu" && act_val[l][DW-1]) act_val[l] = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  // Next-state: fill vector, MAC one group, activate, drain group results.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (x_valid && x_last) state_nxt = S_MAC;
      S_MAC:   if (i_last) state_nxt = S_ACT;
      S_ACT:   state_nxt = S_OUT;
      S_OUT:   if (o_ready && out_end) state_nxt = out_final ? S_FILL : S_MAC;
      default: state_nxt = S_FILL;
    endcase
  end

  // Outputs decode from state and registered lane results only.
  always_comb begin
    x_ready = (state == S_FILL);
    busy    = (state != S_FILL);
    o_valid = (state == S_OUT);
    o_data  = '0;
    o_index = '0;
    o_last  = 1'b0;
    if (state == S_OUT) begin
      o_data  = res[lcnt];
      o_index = IDX_W'(out_n);
      o_last  = out_final;
    end
  end

  // Datapath: input buffer, accumulators, result registers and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xcnt <= '0;
      icnt <= '0;
      grp  <= '0;
      lcnt <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc[l] <= '0;
        res[l] <= '0;
      end
      for (int i = 0; i < NUM_INPUT; i++) x_buf[i] <= '0;
    end else begin
      case (state)
        S_FILL: if (x_valid) begin
          x_buf[xcnt] <= x_in;
          xcnt        <= x_last ? '0 : xcnt + XW'(1);
        end
        S_MAC: begin
          for (int l = 0; l < LANES; l++)
            if (lane_ok[l]) acc[l] <= acc[l] + ACC_W'(prod[l]);
          icnt <= i_last ? '0 : icnt + XW'(1);
        end
        S_ACT: begin
          for (int l = 0; l < LANES; l++) begin
            res[l] <= act_val[l];
            acc[l] <= '0;
          end
          lcnt <= '0;
        end
        S_OUT: if (o_ready) begin
          if (out_end) begin
            lcnt <= '0;
            grp  <= out_final ? '0 : grp + GW'(1);
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_tmux.sv
// Bench for fc_layer_tmux: two instances (relu / none) share stimulus; a
// reference model computes each neuron with plain integer arithmetic and a
// monitor pops expected results on every output handshake.
`timescale 1ns/1ps
module tb_fc_layer_tmux;
  localparam int NN = 3, NI = 4, LN = 2, DW = 16, LAYER = 5, FRAC = DW - 1;
  localparam int W = DW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          weightValid, biasValid;
  logic [31:0]   weightValue, biasValue, config_layer_num, config_neuron_num;
  logic          x_valid, o_ready;
  logic [DW-1:0] x_in;
  wire           xr_r, busy_r, ov_r, ol_r, xr_n, busy_n, ov_n, ol_n;
  wire [DW-1:0]  od_r, od_n;
  wire [1:0]     oi_r, oi_n;

  fc_layer_tmux #(.NUM_NEURON(NN), .NUM_INPUT(NI), .LANES(LN), .DATA_WIDTH(DW),
                  .INT_WIDTH(1), .LAYER_NUM(LAYER), .ACT_TYPE("relu")) dut_r (
    .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_ready(xr_r), .x_in(x_in), .o_valid(ov_r),
    .o_ready(o_ready), .o_data(od_r), .o_index(oi_r), .o_last(ol_r), .busy(busy_r));

  fc_layer_tmux #(.NUM_NEURON(NN), .NUM_INPUT(NI), .LANES(LN), .DATA_WIDTH(DW),
                  .INT_WIDTH(1), .LAYER_NUM(LAYER), .ACT_TYPE("none")) dut_n (
    .clk(clk), .rst(rst), .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_ready(xr_n), .x_in(x_in), .o_valid(ov_n),
    .o_ready(o_ready), .o_data(od_n), .o_index(oi_n), .o_last(ol_n), .busy(busy_n));

  // ---------------- reference model / scoreboard ----------------
  logic signed [DW-1:0] w_ref [NN][NI];
  logic signed [DW-1:0] b_ref [NN];
  logic signed [DW-1:0] x_vec [NI];
  int m_wcnt, m_wlast;
  logic [W-1:0] exp_q_r[$];
  logic [W-1:0] exp_q_n[$];
  int checks = 0, errors = 0;
  int rdy_mode = 0;
  bit mon_clear = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] ref_neuron(int n, bit relu);
    longint s;
    s = 0;
    for (int i = 0; i < NI; i++) s += longint'(x_vec[i]) * longint'(w_ref[n][i]);
    s += longint'(b_ref[n]) * (longint'(1) << FRAC);
    s = s >>> FRAC;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return DW'(s);
  endfunction

  function automatic void push_expected();
    for (int n = 0; n < NN; n++) begin
      exp_q_r.push_back({(n == NN - 1), 2'(n), ref_neuron(n, 1'b1)});
      exp_q_n.push_back({(n == NN - 1), 2'(n), ref_neuron(n, 1'b0)});
    end
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] v;
    if ($urandom_range(0, 3) == 0) v = DW'($urandom);
    else v = DW'($urandom_range(0, 16384)) - 16'd8192;
    return v;
  endfunction

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic cfg_weight(int layer, int neuron, logic [DW-1:0] v, bit busy_exp);
    int col;
    weightValid = 1'b1; config_layer_num = layer; config_neuron_num = neuron;
    weightValue = {16'($urandom), v};
    @(posedge clk); #1;
    weightValid = 1'b0;
    if (layer == LAYER && neuron < NN && !busy_exp) begin
      col = (neuron != m_wlast) ? 0 : m_wcnt;
      w_ref[neuron][col] = v;
      m_wcnt  = (col == NI - 1) ? 0 : col + 1;
      m_wlast = neuron;
    end
  endtask

  task automatic cfg_bias(int layer, int neuron, logic [DW-1:0] v, bit busy_exp);
    biasValid = 1'b1; config_layer_num = layer; config_neuron_num = neuron;
    biasValue = {16'($urandom), v};
    @(posedge clk); #1;
    biasValid = 1'b0;
    if (layer == LAYER && neuron < NN && !busy_exp) b_ref[neuron] = v;
  endtask

  task automatic load_const(logic [DW-1:0] wv, logic [DW-1:0] bv);
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) cfg_weight(LAYER, n, wv, 1'b0);
      cfg_bias(LAYER, n, bv, 1'b0);
    end
  endtask

  task automatic load_rand();
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) cfg_weight(LAYER, n, rnd_val(), 1'b0);
      cfg_bias(LAYER, n, rnd_val(), 1'b0);
    end
  endtask

  task automatic send_vec(bit gaps);
    int t;
    for (int i = 0; i < NI; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      x_valid = 1'b1; x_in = x_vec[i];
      t = 0;
      @(negedge clk);
      while (!xr_r && t < 200) begin @(negedge clk); t++; end
      if (!xr_r) begin checks++; errors++; $display("FAIL x_accept_timeout actual=0 required=1"); end
      @(posedge clk); #1;
      x_valid = 1'b0;
    end
    push_expected();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q_r.size() != 0 || exp_q_n.size() != 0) && t < 2000) begin
      @(posedge clk); t++;
    end
    #1;
    check("drain_relu", exp_q_r.size(), 0);
    check("drain_none", exp_q_n.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; mon_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q_r.delete(); exp_q_n.delete();
    m_wcnt = 0; m_wlast = 0;
    rst = 1'b0; mon_clear = 1'b0;
    check("rst_x_ready", {xr_r, xr_n}, 2'b11);
    check("rst_busy", {busy_r, busy_n}, 2'b00);
    check("rst_o_valid", {ov_r, ov_n}, 2'b00);
    check("rst_o_data", {od_r, od_n}, 32'h0);
    check("rst_o_index", {oi_r, oi_n}, 4'h0);
    check("rst_o_last", {ol_r, ol_n}, 2'b00);
  endtask

  task automatic set_x(logic [DW-1:0] v);
    for (int i = 0; i < NI; i++) x_vec[i] = v;
  endtask

  task automatic rand_x();
    for (int i = 0; i < NI; i++) x_vec[i] = rnd_val();
  endtask

  // ---------------- o_ready driver ----------------
  initial begin
    o_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = 1'($urandom_range(0, 1));
        default: o_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] held [2];
    bit held_v [2];
    bit pend [2];
    logic [W-1:0] cur, e;
    bit ov, xr, empty;
    held_v[0] = 0; held_v[1] = 0; pend[0] = 0; pend[1] = 0;
    forever begin
      @(negedge clk);
      if (rst || mon_clear) begin
        held_v[0] = 0; held_v[1] = 0; pend[0] = 0; pend[1] = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (k == 0) begin ov = ov_r; xr = xr_r; cur = {ol_r, oi_r, od_r}; empty = (exp_q_r.size() == 0); end
          else        begin ov = ov_n; xr = xr_n; cur = {ol_n, oi_n, od_n}; empty = (exp_q_n.size() == 0); end
          if (pend[k]) begin check("x_ready_after_last", xr, 1); pend[k] = 0; end
          if (held_v[k]) begin
            check("hold_valid", ov, 1);
            if (ov) check("hold_payload", cur, held[k]);
          end
          held_v[k] = 0;
          if (ov) begin
            if (o_ready) begin
              if (empty) begin
                checks++; errors++;
                $display("FAIL unexpected_output dut=%0d actual=%h required=none", k, cur);
              end else begin
                if (k == 0) e = exp_q_r.pop_front(); else e = exp_q_n.pop_front();
                check((k == 0) ? "result_relu" : "result_none", cur, e);
              end
              if (cur[W-1]) pend[k] = 1;
            end else begin
              held_v[k] = 1; held[k] = cur;
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst = 1'b1; weightValid = 0; biasValid = 0; weightValue = 0; biasValue = 0;
    config_layer_num = 0; config_neuron_num = 0; x_valid = 0; x_in = 0;
    m_wcnt = 0; m_wlast = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Basic: 0.25 * 0.5 * 4 = 0.5, plus latency and group timing.
    load_const(16'h2000, 16'h0000);
    set_x(16'h4000);
    send_vec(1'b0);
    @(negedge clk);
    check("mac_x_ready", xr_r, 0);
    check("mac_busy", busy_r, 1);
    k = 1;
    while (!ov_r && k < 20) begin @(negedge clk); k++; end
    check("first_latency", k, NI + 2);
    @(negedge clk);
    check("back_to_back", {ov_r, oi_r}, {1'b1, 2'd1});
    k = 0;
    do begin @(negedge clk); k++; end while (!ov_r && k < 20);
    check("group_gap", k, NI + 2);
    check("last_group_tag", {ol_r, oi_r}, {1'b1, 2'd2});
    @(posedge clk); #1;
    wait_idle();

    // Negative result: relu clamps, none keeps -0.5; then bias cancels it.
    load_const(16'hE000, 16'h0000);
    send_vec(1'b0);
    wait_idle();
    for (int n = 0; n < NN; n++) cfg_bias(LAYER, n, 16'h4000, 1'b0);
    send_vec(1'b0);
    wait_idle();

    // Saturation both directions.
    load_const(16'h7FFF, 16'h0000);
    set_x(16'h7FFF);
    send_vec(1'b0);
    wait_idle();
    load_const(16'h8000, 16'h0000);
    send_vec(1'b0);
    wait_idle();

    // Backpressure: hold o_ready low five cycles mid-stream.
    load_rand();
    rand_x();
    send_vec(1'b0);
    k = 0;
    while (!ov_r && k < 30) begin @(negedge clk); k++; end
    check("stall_setup_valid", ov_r, 1);
    rdy_mode = 2;
    repeat (6) @(posedge clk);
    rdy_mode = 0;
    #1;
    wait_idle();

    // Dropped writes: wrong layer, neuron out of range, while busy; x while busy.
    cfg_weight(LAYER + 1, 0, rnd_val(), 1'b0);
    cfg_weight(LAYER, NN, rnd_val(), 1'b0);
    cfg_bias(LAYER - 1, 1, rnd_val(), 1'b0);
    cfg_bias(LAYER, NN + 4, rnd_val(), 1'b0);
    rand_x();
    send_vec(1'b0);
    x_valid = 1'b1; x_in = rnd_val();
    cfg_weight(LAYER, 0, rnd_val(), 1'b1);
    cfg_weight(LAYER, 1, rnd_val(), 1'b1);
    cfg_bias(LAYER, 2, rnd_val(), 1'b1);
    x_valid = 1'b0;
    wait_idle();
    rand_x();
    send_vec(1'b1);
    wait_idle();

    // Write pointer: restart on neuron change, wrap after NUM_INPUT.
    cfg_weight(LAYER, 1, rnd_val(), 1'b0);
    cfg_weight(LAYER, 1, rnd_val(), 1'b0);
    for (int i = 0; i < NI; i++) cfg_weight(LAYER, 0, rnd_val(), 1'b0);
    for (int i = 0; i < NI + 1; i++) cfg_weight(LAYER, 2, rnd_val(), 1'b0);
    rand_x();
    send_vec(1'b0);
    wait_idle();

    // Reset during MAC, then same weights must still work.
    rand_x();
    send_vec(1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    rand_x();
    send_vec(1'b0);
    wait_idle();

    // Randomized runs with random backpressure and input gaps.
    for (int r = 0; r < 10; r++) begin
      rdy_mode = 0;
      @(posedge clk); #1;
      load_rand();
      rdy_mode = 1;
      for (int v = 0; v < 2; v++) begin
        rand_x();
        send_vec(1'b1);
        wait_idle();
      end
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_tmux.md
# fc_layer_tmux

Parametrised, time-multiplexed fully-connected layer: `NUM_NEURON` neurons are evaluated on `LANES` shared MAC lanes instead of one hardware neuron each. The block buffers one input vector, then for each group of `LANES` neurons accumulates weight×input products, adds bias, applies activation with saturation, and streams results out with valid/ready backpressure. Weights and biases load over the same config bus used by the existing per-neuron layers, so it drops into the layer chain in place of a fully-parallel layer.

## Interface
- `NUM_NEURON`, 10, neurons in layer
- `NUM_INPUT`, 10, inputs per vector (weights per neuron)
- `LANES`, 2, parallel MAC lanes (1..NUM_NEURON)
- `DATA_WIDTH`, 16, signed data/weight/bias width
- `INT_WIDTH`, 1, integer bits incl. sign; FRAC = DATA_WIDTH-INT_WIDTH
- `LAYER_NUM`, 5, layer id matched against `config_layer_num`
- `ACT_TYPE`, "relu", "relu" or "none"

Reset: one clock; reset is asynchronous and active-high.
- `clk` in 1 clock
- `rst` in 1 async active-high reset
- `weightValid` in 1 weight write strobe
- `biasValid` in 1 bias write strobe
- `weightValue` in 32 weight, low DATA_WIDTH bits used
- `biasValue` in 32 bias, low DATA_WIDTH bits used
- `config_layer_num` in 32 target layer
- `config_neuron_num` in 32 target neuron
- `x_valid` in 1 input sample valid
- `x_ready` out 1 input accepted when `x_valid&&x_ready`
- `x_in` in DATA_WIDTH input sample
- `o_valid` out 1 result valid
- `o_ready` in 1 downstream accept
- `o_data` out DATA_WIDTH activated result
- `o_index` out clog2(NUM_NEURON) neuron number of `o_data`
- `o_last` out 1 marks result of neuron NUM_NEURON-1
- `busy` out 1 high in any state except FILL

## Operation
- Config: write accepted only when `config_layer_num==LAYER_NUM`, `config_neuron_num<NUM_NEURON`, `busy==0`; otherwise dropped.
- Weight write goes to `w[neuron][wcnt]`; `wcnt` increments per accepted weight, wraps at NUM_INPUT, clears to 0 when `config_neuron_num` differs from last accepted weight's neuron.
- Bias write: `b[neuron] <= biasValue[DATA_WIDTH-1:0]`.
- States: FILL -> MAC -> ACT -> OUT -> (MAC next group | FILL).
- FILL: `x_ready=1`; accepted samples stored at xcnt 0..NUM_INPUT-1; after the NUM_INPUT-th accept go MAC, group g=0.
- MAC: NUM_INPUT cycles; cycle i, lane l (neuron n=g*LANES+l): `acc[l] += x[i]*w[n][i]`. Products 2*DATA_WIDTH signed; ACC_WIDTH = 2*DATA_WIDTH+clog2(NUM_INPUT)+1, no overflow possible.
- ACT (1 cycle): `s = (acc + (b<<FRAC)) >>> FRAC`; saturate to [-2^(DW-1), 2^(DW-1)-1]; relu maps negative to 0; register per-lane results; clear acc.
- OUT: present lanes in order l=0..; lanes with n>=NUM_NEURON skipped (partial final group). Advance on `o_valid&&o_ready`. After last lane: if n==NUM_NEURON-1 go FILL else g++ and go MAC.
- Weights/biases are not cleared by reset.

## Timing
- Reset values: state FILL, `x_ready=1`, `busy=0`, `o_valid=0`, `o_data=0`, `o_index=0`, `o_last=0`, all counters/accumulators 0.
- Reset mid-operation: partial vector and results discarded; loaded weights/biases retained.
- Last FILL accept at cycle T -> `x_ready=0`, `busy=1` at T+1; MAC cycles T+1..T+NUM_INPUT; ACT T+NUM_INPUT+1; first `o_valid` T+NUM_INPUT+2.
- Each further group adds NUM_INPUT+1 cycles after its last output handshake; with `o_ready` held high, one result per cycle within a group.
- `o_data/o_index/o_last` stable while `o_valid && !o_ready`.
- `x_ready` returns 1 the cycle after the `o_last` handshake; `x_valid` while `x_ready=0` ignored.

## Test plan
- Reset -> all outputs at reset values; `x_ready=1`, `busy=0`.
- NUM_INPUT=4, NUM_NEURON=3, LANES=2, Q1.15: all w=0x2000, b=0, x=0x4000 ×4 -> 3 results 0x4000, o_index 0,1,2, `o_last` only on index 2, group 2 has one lane only.
- w=0xE000 (−0.25), x=0x4000: relu -> 0x0000; ACT_TYPE "none" -> 0xC000; b=0x4000 added -> 0x0000 for "none".
- w=0x7FFF, x=0x7FFF -> 0x7FFF; w=0x8000, x=0x7FFF, "none" -> 0x8000 (saturate).
- `o_ready` low 5 cycles mid-stream -> outputs held stable, no result lost or duplicated; writes with wrong layer, neuron>=NUM_NEURON, or while busy -> no effect on results.
- Reset asserted during MAC -> back to FILL; next vector with same weights gives correct results.
